// File: rtl/prng_scheduler.sv
// prng_scheduler: round-robin arbiter that hands each granted requester a
// 16-bit word from a shared 26-bit Galois-style LFSR. Each grant advances
// the LFSR STEPS times, then presents the low 16 bits until accepted.
//
// Parameters:
//   STEPS       LFSR advances per grant (1..31)
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   seed_load   load seed into the LFSR (honoured in IDLE only)
//   seed[25:0]  seed value (zero is replaced by 1)
//   req[3:0]    level-sensitive requests
//   gnt[3:0]    one-hot grant, held from arbitration until delivery accepted
//   rnd_valid   rnd_data / rnd_id valid
//   rnd_data    random word (LFSR bits 15..0)
//   rnd_id      index of the granted requester
//   rnd_ready   consumer accepts the word when high with rnd_valid
//   busy        high whenever the FSM is not IDLE
// Build option:
//   PRNG_SCHED_PRIO_EN  requester 0 always wins when requesting; round-robin
//                       among requesters 1..3 otherwise.
module prng_scheduler #(
  parameter int STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [25:0] seed,
  input  logic [3:0]  req,
  output logic [3:0]  gnt,
  output logic        rnd_valid,
  output logic [15:0] rnd_data,
  output logic [1:0]  rnd_id,
  input  logic        rnd_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARB, STEP, DELIVER} state_t;

  // Feedback taps: s26 is XORed into s1, s2, s8 and s9 (bits 25, 24, 18, 17).
  localparam logic [25:0] TAPS      = 26'h3060000;
  localparam logic [4:0]  LAST_STEP = 5'(STEPS - 1);

  state_t      state, state_nx;
  logic [25:0] lfsr;
  logic [4:0]  step_cnt;
  logic [1:0]  last_id;
  logic [1:0]  gnt_id;
  logic [1:0]  win_id;
  logic        win_vld;
  logic [1:0]  cand;

  // One right shift with s26 fed back; all-zero recovers to 1.
  function automatic logic [25:0] lfsr_adv(input logic [25:0] s);
    if (s == 26'd0) return 26'd1;
    return (s >> 1) ^ ({26{s[0]}} & TAPS);
  endfunction

  // Round-robin search starting just after last_id. Offsets are scanned from
  // the farthest to the nearest so the nearest requester overwrites the rest.
  always_comb begin
    win_id  = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_id + 2'(k);
`ifdef PRNG_SCHED_PRIO_EN
      if (req[cand] && (cand != 2'd0)) begin
`else
      if (req[cand]) begin
`endif
        win_id  = cand;
        win_vld = 1'b1;
      end
    end
`ifdef PRNG_SCHED_PRIO_EN
    if (req[0]) begin
      win_id  = 2'd0;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = ARB;
      ARB:     state_nx = win_vld ? STEP : IDLE;
      STEP:    if (step_cnt == LAST_STEP) state_nx = DELIVER;
      DELIVER: if (rnd_valid && rnd_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= 26'd1;
      step_cnt  <= 5'd0;
      last_id   <= 2'd3;
      gnt_id    <= 2'd0;
      gnt       <= 4'd0;
      rnd_valid <= 1'b0;
      rnd_data  <= 16'd0;
      rnd_id    <= 2'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= (seed == 26'd0) ? 26'd1 : seed;
        end
        ARB: begin
          if (win_vld) begin
            gnt      <= 4'b0001 << win_id;
            gnt_id   <= win_id;
            step_cnt <= 5'd0;
          end
        end
        STEP: begin
          lfsr     <= lfsr_adv(lfsr);
          step_cnt <= step_cnt + 5'd1;
        end
        DELIVER: begin
          // Output word is registered on the first DELIVER cycle, which gives
          // the STEPS+1 grant-to-valid latency.
          if (!rnd_valid) begin
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr[15:0];
            rnd_id    <= gnt_id;
          end else if (rnd_ready) begin
            rnd_valid <= 1'b0;
            gnt       <= 4'd0;
            last_id   <= gnt_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_prng_scheduler.sv
module tb_prng_scheduler;

  localparam int STEPS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [25:0] seed = 26'd0;
  logic [3:0]  req = 4'd0;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic [1:0]  rnd_id;
  logic        rnd_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  prng_scheduler #(.STEPS(STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_id(rnd_id), .rnd_ready(rnd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 arbitrate, 2 stepping, 3 delivering
  int          m_mode = 0;
  int          m_cnt  = 0;
  logic [25:0] m_lfsr = 26'd1;
  logic [3:0]  m_gnt  = 4'd0;
  logic        m_valid = 1'b0;
  logic [15:0] m_data = 16'd0;
  logic [1:0]  m_id   = 2'd0;
  int          m_last = 3;
  int          m_gid  = 0;

  // One LFSR advance written directly from the s1..s26 bit equations.
  function automatic logic [25:0] m_adv(input logic [25:0] v);
    logic s [1:26];
    logic n [1:26];
    logic [25:0] r;
    if (v == 26'd0) return 26'd1;
    for (int i = 1; i <= 26; i++) s[i] = v[26-i];
    n[1] = s[26];
    n[2] = s[1] ^ s[26];
    for (int i = 3; i <= 7; i++) n[i] = s[i-1];
    n[8] = s[7] ^ s[26];
    n[9] = s[8] ^ s[26];
    for (int i = 10; i <= 26; i++) n[i] = s[i-1];
    for (int i = 1; i <= 26; i++) r[26-i] = n[i];
    return r;
  endfunction

  function automatic int m_pick(input logic [3:0] r, input int last);
    int w;
    w = -1;
`ifdef PRNG_SCHED_PRIO_EN
    if (r[0]) return 0;
    for (int k = 1; k <= 4; k++)
      if (w < 0 && ((last + k) % 4) != 0 && r[(last + k) % 4]) w = (last + k) % 4;
`else
    for (int k = 1; k <= 4; k++)
      if (w < 0 && r[(last + k) % 4]) w = (last + k) % 4;
`endif
    return w;
  endfunction

  task automatic model_update();
    int w;
    if (!rst_n) begin
      m_mode = 0; m_lfsr = 26'd1; m_gnt = 4'd0; m_valid = 1'b0;
      m_data = 16'd0; m_id = 2'd0; m_last = 3; m_cnt = 0;
    end else begin
      case (m_mode)
        0: begin
          if (seed_load) m_lfsr = (seed == 26'd0) ? 26'd1 : seed;
          if (req != 4'd0) m_mode = 1;
        end
        1: begin
          w = m_pick(req, m_last);
          if (w < 0) m_mode = 0;
          else begin
            m_gid = w; m_gnt = 4'(1 << w); m_cnt = 0; m_mode = 2;
          end
        end
        2: begin
          m_lfsr = m_adv(m_lfsr);
          m_cnt++;
          if (m_cnt == STEPS) m_mode = 3;
        end
        default: begin
          if (!m_valid) begin
            m_valid = 1'b1; m_data = m_lfsr[15:0]; m_id = 2'(m_gid);
          end else if (rnd_ready) begin
            m_valid = 1'b0; m_gnt = 4'd0; m_last = m_gid; m_mode = 0;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int         cyc = 0;
  int         gnt_cyc = 0;
  logic       prev_gnt_nz = 1'b0;
  logic       prev_valid = 1'b0;
  logic [3:0] gq[$];

  task automatic compare();
    cyc++;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rnd_valid", 32'(rnd_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("rnd_data", 32'(rnd_data), 32'(m_data));
    chk("rnd_id", 32'(rnd_id), 32'(m_id));
    if (!prev_gnt_nz && gnt != 4'd0) begin
      gnt_cyc = cyc;
      gq.push_back(gnt);
    end
    if (!prev_valid && rnd_valid)
      chk("latency", 32'(cyc - gnt_cyc), 32'(STEPS + 1));
    prev_gnt_nz = (gnt != 4'd0);
    prev_valid  = rnd_valid;
  endtask

  // Inputs change at negedge; both DUT and model sample them at posedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic run_until_valid(input string name, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (rnd_valid) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] hold_data;
    logic [1:0]  hold_id;
    logic [3:0]  exp_order [5];

    // Model pins against hand-derived values.
    chk("model_adv_1", 32'(m_adv(26'd1)), 32'h3060000);
    chk("model_adv_0", 32'(m_adv(26'd0)), 32'd1);

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rnd_valid), 32'd0);
    chk("rst_data", 32'(rnd_data), 32'd0);
    chk("rst_id", 32'(rnd_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Seed 0x2000000 loaded together with req=0010
    rst_n = 1'b1; seed_load = 1'b1; seed = 26'h2000000; req = 4'b0010; rnd_ready = 1'b1;
    step();
    seed_load = 1'b0;
    run_until_valid("seeded", 100);
    chk("seeded_data", 32'(rnd_data), 32'h0200);
    chk("seeded_id", 32'(rnd_id), 32'd1);
    req = 4'd0;
    step(); step();

    // Back-pressure: held outputs, seed_load ignored while delivering
    req = 4'b0100; rnd_ready = 1'b0;
    run_until_valid("stall", 100);
    req = 4'd0;
    hold_data = rnd_data; hold_id = rnd_id;
    for (int i = 0; i < 5; i++) begin
      seed_load = 1'b1; seed = 26'($urandom);
      step();
      chk("stall_data", 32'(rnd_data), 32'(hold_data));
      chk("stall_id", 32'(rnd_id), 32'(hold_id));
      chk("stall_valid", 32'(rnd_valid), 32'd1);
    end
    seed_load = 1'b0; rnd_ready = 1'b1;
    step(); step();

    // Grant order with all requesters active, from reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    gq.delete();
    req = 4'b1111; rnd_ready = 1'b1;
    for (int i = 0; i < 400 && gq.size() < 5; i++) step();
    req = 4'd0;
`ifdef PRNG_SCHED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    chk("order_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("order", 32'(gq[i]), 32'(exp_order[i]));
    for (int i = 0; i < 40; i++) step();

    // Zero seed, then reset while stepping
    seed_load = 1'b1; seed = 26'd0; req = 4'b1000;
    step();
    seed_load = 1'b0;
    run_until_valid("zero_seed", 100);
    step();
    req = 4'b0001; rnd_ready = 1'b1;
    step(); step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(rnd_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; req = 4'd0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      rnd_ready = ($urandom_range(0, 2) != 0);
      seed_load = ($urandom_range(0, 7) == 0);
      seed      = ($urandom_range(0, 9) == 0) ? 26'd0 : 26'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/prng_scheduler.md
PRNG_SCHEDULER -- requirements
Module: prng_scheduler

Interface
REQ-001 Parameter STEPS, default 16, is the number of LFSR advances per grant; legal range 1..31.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 seed_load  input  1  load seed into the LFSR this cycle.
REQ-005 seed  input  26  seed value.
REQ-006 req  input  4  per-requester request, level-sensitive.
REQ-007 gnt  output  4  one-hot grant, held from ARB decision until delivery accepted.
REQ-008 rnd_valid  output  1  rnd_data/rnd_id valid.
REQ-009 rnd_data  output  16  random word.
REQ-010 rnd_id  output  2  index of the granted requester.
REQ-011 rnd_ready  input  1  consumer accepts the word when high with rnd_valid.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The LFSR state shall be 26 bits s1..s26 (s1 = MSB, s26 = LSB of the 26-bit value).
REQ-014 One advance shall be: s1<=s26; s2<=s1^s26; s3..s7<=s2..s6; s8<=s7^s26; s9<=s8^s26; s10..s26<=s9..s25.
REQ-015 If the state is all-zero at an advance, the next state shall be 26'd1 instead.
REQ-016 FSM states: IDLE, ARB, STEP, DELIVER.
REQ-017 IDLE -> ARB when any req bit is high; otherwise remain in IDLE.
REQ-018 In ARB (1 cycle), round-robin: the first requesting index after the last-served index wins, wrapping 3->0; after reset, index 0 has highest priority; gnt is asserted next cycle, FSM -> STEP.
REQ-019 If req drops to all-zero in ARB, FSM shall return to IDLE with no grant.
REQ-020 STEP shall advance the LFSR once per cycle for exactly STEPS cycles, then -> DELIVER.
REQ-021 In DELIVER, rnd_valid=1, rnd_data=s11..s26 (s26 = bit 0), and rnd_id=the granted index; the values are held stable until rnd_ready.
REQ-022 When rnd_valid and rnd_ready are both high: update the last-served pointer, clear gnt and rnd_valid next cycle, and go to IDLE.
REQ-023 A requester deasserting req after its grant shall not abort the sequence.
REQ-024 seed_load shall be honoured in IDLE only: state<=seed, or 26'd1 if seed==0; it shall be ignored in other states.
REQ-025 If seed_load and a req are both high in IDLE, the seed loads and ARB begins in the same cycle.
REQ-026 Grant-to-rnd_valid latency shall be STEPS+1 cycles.

Reset
REQ-027 On rst_n=0 at a clock edge: FSM=IDLE, LFSR=26'd1, gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, busy=0, last-served pointer=3.
REQ-028 Reset asserted mid-sequence shall abort it with no delivery; reset dominates seed_load.

Configuration
REQ-029 Macro PRNG_SCHED_PRIO_EN defined: in ARB, req[0] shall win whenever set, and round-robin applies only among indices 1..3.
REQ-030 Macro PRNG_SCHED_PRIO_EN undefined: pure 4-way round-robin per REQ-018.

Verification
REQ-031 Reset, then req=4'b0001, rnd_ready=1, STEPS=1 -> gnt=0001, rnd_data=16'h0000, LFSR=26'h3060000 after delivery.
REQ-032 seed=26'h2000000 with seed_load in IDLE, req=0010, STEPS=16 -> rnd_id=1, rnd_data=16'h0200, valid STEPS+1 cycles after gnt.
REQ-033 req=4'b1111 held, rnd_ready=1 -> gnt order 0001,0010,0100,1000,0001; with PRIO_EN -> 0001 every grant.
REQ-034 rnd_ready held low for 5 DELIVER cycles -> rnd_valid, rnd_data and rnd_id stable; seed_load pulses during this window ignored.
REQ-035 seed=0 with seed_load -> LFSR=26'd1; rst_n low during STEP -> next cycle IDLE, gnt=0, rnd_valid=0.
